// File: rtl/byte_load_store_unit.sv
// Byte load/store unit: one LB/SB access per start on a word-wide req/ack bus.
// Optional bus timeout abort is compiled in with `define LSU_TIMEOUT_EN.
module byte_load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] byte_sel;
    logic [7:0] sel_byte;
    logic       timeout_hit;
    logic       access_req;

    assign access_req = mem_read | mem_write;
    assign sel_byte   = bus_rdata[8*byte_sel +: 8];

    // Status outputs are pure decodes of the state register, so reset clears them.
    assign busy    = (state == REQ);
    assign bus_req = (state == REQ);
    assign done    = (state == DONE);

`ifdef LSU_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    assign timeout_hit = (state == REQ) && !bus_ack && (tmo_cnt == TMO_LAST);
    assign err         = err_q;

    // Held at zero outside REQ, so every entry into REQ starts a fresh count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (state == REQ && !bus_ack)
                tmo_cnt <= tmo_cnt + 8'd1;
            else
                tmo_cnt <= 8'd0;

            if (state == IDLE && start)
                err_q <= 1'b0;
            else if (state == REQ)
                err_q <= timeout_hit;
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
    assign unused_cfg  = ^TMO_LAST;
`endif

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_nxt unassigned, which would infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = access_req ? REQ : DONE;
            end
            REQ: begin
                if (bus_ack || timeout_hit)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_wstrb <= 4'd0;
            byte_sel  <= 2'd0;
            rdata     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && access_req) begin
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= {4{wdata[7:0]}};
                        bus_wstrb <= mem_write ? (4'b0001 << addr[1:0]) : 4'b0000;
                        byte_sel  <= addr[1:0];
                    end
                end
                REQ: begin
                    if (bus_ack && !bus_we)
                        rdata <= {{24{sel_byte[7]}}, sel_byte};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/byte_load_store_unit.md
Name: byte_load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RISC-V datapath.
- Consumes the ALU result as the effective address for LB/SB and runs one byte access on a word-wide request/acknowledge memory bus.
- Stalls the pipeline while the access is in flight.
- Returns the sign-extended load byte to write-back.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in REQ without bus_ack before abort. Only used when LSU_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  access request from the execute stage; sampled in IDLE only.
- mem_read  input  1  LB request; qualified by start.
- mem_write  input  1  SB request; qualified by start.
- addr  input  32  effective address (ALU result).
- wdata  input  32  store data (rs2); only bits [7:0] are used.
- busy  output  1  high from the cycle after start is accepted until done; pipeline stall.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 means the access timed out.
- rdata  output  32  sign-extended load byte; holds its value until the next successful load.
- bus_req  output  1  bus request; held high until bus_ack is sampled.
- bus_we  output  1  1 means write.
- bus_addr  output  32  word-aligned address {addr[31:2], 2'b00}.
- bus_wdata  output  32  {4{wdata[7:0]}}.
- bus_wstrb  output  4  byte enable = 4'b0001 << addr[1:0]; 4'b0000 for reads.
- bus_ack  input  1  bus completion; sampled only while bus_req is high.
- bus_rdata  input  32  read data; valid in the bus_ack cycle.

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of the current state:
  - state becomes IDLE;
  - busy, done, err, bus_req and bus_we become 0;
  - rdata, bus_addr and bus_wdata become 0; bus_wstrb becomes 0;
  - the timeout counter clears.
- Reset mid-access: bus_req drops at that edge. A late bus_ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - start=1 with mem_write=1: latch the bus fields with bus_we=1, go to REQ. mem_write wins if mem_read is also 1.
  - start=1 with mem_read=1 only: latch the bus fields with bus_we=0, go to REQ.
  - start=1 with neither set: go to DONE with no bus transaction; err=0; rdata unchanged.
  - start=0: stay in IDLE.
- REQ:
  - bus_req=1 and busy=1.
  - bus_addr, bus_we, bus_wdata and bus_wstrb stay constant.
  - On the edge where bus_ack=1 is sampled:
    - for a read, rdata <= sign-extended bus_rdata[8*addr[1:0] +: 8], with addr as latched at start;
    - go to DONE and drop bus_req at that same edge.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start is not accepted in DONE; the earliest new start is sampled in the cycle after done.
- Latency:
  - start accepted at edge 0; bus_req high after edge 0.
  - bus_ack sampled at edge N gives done high for the cycle after edge N.
  - A zero-wait bus (ack in the first REQ cycle) gives done 2 cycles after start.
- start, mem_read, mem_write, addr and wdata are ignored outside IDLE.
- bus_ack while bus_req=0 is ignored.
- Sign extension: bit 7 of the selected byte is replicated into rdata[31:8].

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without bus_ack.
  - When it reaches TIMEOUT_CYCLES: drop bus_req, go to DONE with err=1, leave rdata unchanged.
  - If bus_ack arrives in the same cycle the count is reached, the ack wins and err=0.
- Not defined:
  - No counter; REQ waits indefinitely for bus_ack.
  - The err port still exists and is tied to 0.

Test Plan:
- LB, zero-wait: addr=0x0000_1003, bus_rdata=0x80FF_1234, bus_ack in the first REQ cycle.
  - Required: bus_addr=0x0000_1000, bus_wstrb=0, bus_we=0.
  - Required: done pulse 2 cycles after start, rdata=0xFFFF_FF80, err=0.
- SB, 3 wait states: addr=0x0000_2001, wdata=0x1234_56A5, bus_ack 3 cycles late.
  - Required: bus_wdata=0xA5A5_A5A5, bus_wstrb=4'b0010, bus_we=1; request fields stable for all 4 REQ cycles.
  - Required: busy high for 4 cycles, then done; rdata keeps its previous value.
- Both flags, then neither:
  - start with mem_read=mem_write=1: performs a write.
  - start with neither flag: done one cycle after start, no bus_req ever.
- Busy rejection: start re-asserted with a new addr while in REQ and in DONE.
  - Required: ignored; the bus fields keep the first access values.
- Reset mid-access: rst_n=0 for one edge while bus_req=1; assert bus_ack afterwards.
  - Required: bus_req, busy and done all 0 after that edge; the late ack produces no done.
- Timeout, with LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: never assert bus_ack.
  - Required: bus_req drops after 4 REQ cycles; done=1 with err=1; rdata unchanged.
  - Without the macro: bus_req stays high for 100 cycles and err stays 0.
